dcache_miss_arbiter: RTL and testbench

//  Sequences Dcache miss handling for two cores sharing one main-memory port.

---
 rtl/dcache_miss_arbiter_if.sv | 37 +++
 rtl/dcache_miss_arbiter.sv | 132 +++++++++++++
 tb/tb_dcache_miss_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_miss_arbiter_if.sv
// Miss/fill and shared memory port bundle for dcache_miss_arbiter.
// master = the arbiter, slave = the cores plus memory around it.
interface dcache_miss_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned LINE_W = 64
);
  logic              miss_req0, miss_req1;
  logic [ADDR_W-1:0] miss_addr0, miss_addr1;
  logic              vic_dirty0, vic_dirty1;
  logic [TAG_W-1:0]  vic_tag0, vic_tag1;
  logic [LINE_W-1:0] vic_line0, vic_line1;
  logic              miss_done0, miss_done1;
  logic [LINE_W-1:0] fill_line;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_re, mem_we;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_rdy;
  logic              busy;

  modport master (
    input  miss_req0, miss_req1, miss_addr0, miss_addr1,
           vic_dirty0, vic_dirty1, vic_tag0, vic_tag1, vic_line0, vic_line1,
           mem_rdata, mem_rdy,
    output miss_done0, miss_done1, fill_line, mem_addr, mem_re, mem_we,
           mem_wdata, busy
  );

  modport slave (
    output miss_req0, miss_req1, miss_addr0, miss_addr1,
           vic_dirty0, vic_dirty1, vic_tag0, vic_tag1, vic_line0, vic_line1,
           mem_rdata, mem_rdy,
    input  miss_done0, miss_done1, fill_line, mem_addr, mem_re, mem_we,
           mem_wdata, busy
  );
endinterface

// File: rtl/dcache_miss_arbiter.sv
// Round-robin miss sequencer for two Dcaches sharing one memory port:
// optional dirty-victim write-back, line fetch, then a one-cycle fill pulse.
module dcache_miss_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned LINE_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dcache_miss_arbiter_if.master bus
);
  localparam int unsigned LA_W  = ADDR_W - 2;
  localparam int unsigned IDX_W = ADDR_W - 2 - TAG_W;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;
  logic [LA_W-1:0]   line_addr_q, line_addr_d;
  logic [LA_W-1:0]   vic_addr_q, vic_addr_d;
  logic [LINE_W-1:0] vic_line_q, vic_line_d;
  logic [LINE_W-1:0] fill_q, fill_d;
  logic [LA_W-1:0]   mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              busy_q, busy_d;

  logic              req0, req1, sel;
  logic [ADDR_W-1:0] sel_addr;

  logic unused;
  assign unused = ^{bus.miss_addr0[1:0], bus.miss_addr1[1:0]};

  // The done pulse lands in the first IDLE cycle while its core still holds
  // req; masking that core avoids re-granting an already-served miss.
  assign req0     = bus.miss_req0 & ~done0_q;
  assign req1     = bus.miss_req1 & ~done1_q;
  assign sel      = (req0 & req1) ? rr_q : req1;
  assign sel_addr = sel ? bus.miss_addr1 : bus.miss_addr0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    line_addr_d = line_addr_q;
    vic_addr_d  = vic_addr_q;
    vic_line_d  = vic_line_q;
    fill_d      = fill_q;

    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          owner_d     = sel;
          rr_d        = ~sel;
          line_addr_d = sel_addr[ADDR_W-1:2];
          vic_addr_d  = sel ? {bus.vic_tag1, sel_addr[IDX_W+1:2]}
                            : {bus.vic_tag0, sel_addr[IDX_W+1:2]};
          vic_line_d  = sel ? bus.vic_line1 : bus.vic_line0;
          state_d     = (sel ? bus.vic_dirty1 : bus.vic_dirty0) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (bus.mem_rdy) state_d = S_FILL;
      end
      S_FILL: begin
        if (bus.mem_rdy) begin
          fill_d  = bus.mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the upcoming state.
    mem_we_d    = (state_d == S_WB);
    mem_re_d    = (state_d == S_FILL);
    mem_addr_d  = (state_d == S_WB)   ? vic_addr_d :
                  (state_d == S_FILL) ? line_addr_d : '0;
    mem_wdata_d = (state_d == S_WB) ? vic_line_d : '0;
    busy_d      = (state_d != S_IDLE);
    done0_d     = (state_q == S_DONE) & ~owner_q;
    done1_d     = (state_q == S_DONE) &  owner_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      line_addr_q <= '0;
      vic_addr_q  <= '0;
      vic_line_q  <= '0;
      fill_q      <= '0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      line_addr_q <= line_addr_d;
      vic_addr_q  <= vic_addr_d;
      vic_line_q  <= vic_line_d;
      fill_q      <= fill_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.miss_done0 = done0_q;
  assign bus.miss_done1 = done1_q;
  assign bus.fill_line  = fill_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_dcache_miss_arbiter.sv
// Bench for dcache_miss_arbiter: each granted miss is modelled as a list of
// memory operations followed by one done pulse, with random cores and memory.
module tb_dcache_miss_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_miss_arbiter_if #(.ADDR_W(13), .TAG_W(5), .LINE_W(64)) bus();
  dcache_miss_arbiter #(.ADDR_W(13), .TAG_W(5), .LINE_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic        we;
    logic [10:0] addr;
    logic [63:0] data;
  } cmd_t;
  typedef enum {P_IDLE, P_CMD, P_POST, P_PULSE} phase_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // core side
  bit          want[2], dropped[2], drop_pend[2];
  logic [12:0] c_addr[2];
  logic        c_dirty[2];
  logic [4:0]  c_tag[2];
  logic [63:0] c_line[2];

  // reference model
  cmd_t        q[$];
  phase_e      ph = P_IDLE;
  int          m_owner = 0;
  int          m_rr = 0;
  logic [63:0] fill_exp = '0;
  int          grant_cyc = 0, lat_exp = 0, age = 0, wait_n = 0;
  int          fixed_wait = 0;
  int          rst_cycles = 0;
  bit          rand_cores = 0;
  bit          t5_mode = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic raise(input int i, input logic [12:0] a, input logic d,
                       input logic [4:0] t, input logic [63:0] l);
    want[i] = 1; dropped[i] = 0; drop_pend[i] = 0;
    c_addr[i] = a; c_dirty[i] = d; c_tag[i] = t; c_line[i] = l;
  endtask

  task automatic randomize_core(input int i);
    c_addr[i]  = 13'($urandom);
    c_dirty[i] = 1'($urandom_range(0, 1));
    c_tag[i]   = 5'($urandom);
    c_line[i]  = {$urandom, $urandom};
  endtask

  task automatic drive_cores();
    bus.miss_req0  = want[0] && !dropped[0];
    bus.miss_req1  = want[1] && !dropped[1];
    bus.miss_addr0 = c_addr[0];  bus.miss_addr1 = c_addr[1];
    bus.vic_dirty0 = c_dirty[0]; bus.vic_dirty1 = c_dirty[1];
    bus.vic_tag0   = c_tag[0];   bus.vic_tag1   = c_tag[1];
    bus.vic_line0  = c_line[0];  bus.vic_line1  = c_line[1];
  endtask

  task automatic arbitrate(input bit was_pulse);
    bit r0, r1;
    int s;
    logic [12:0] a;
    r0 = want[0] && !dropped[0] && !(was_pulse && m_owner == 0);
    r1 = want[1] && !dropped[1] && !(was_pulse && m_owner == 1);
    if (r0 || r1) begin
      s = (r0 && r1) ? m_rr : (r0 ? 0 : 1);
      m_rr = 1 - s;
      m_owner = s;
      a = c_addr[s];
      q.delete();
      if (c_dirty[s]) q.push_back({1'b1, c_tag[s], a[7:2], c_line[s]});
      q.push_back({1'b0, a[12:2], 64'h0});
      grant_cyc = cyc;
      lat_exp = c_dirty[s] ? 4 : 3;
      ph = P_CMD;
      age = 0;
    end
  endtask

  task automatic step();
    logic        e_we, e_re, e_busy, e_d0, e_d1, rdy, done_obs;
    logic [10:0] e_addr;
    logic [63:0] e_wd, rd;
    phase_e      cur;
    @(posedge clk);
    #1;
    cyc++;
    e_we = 0; e_re = 0; e_busy = 0; e_d0 = 0; e_d1 = 0; e_addr = '0; e_wd = '0;
    case (ph)
      P_CMD: begin
        e_we = q[0].we; e_re = !q[0].we; e_addr = q[0].addr;
        e_wd = q[0].we ? q[0].data : 64'h0; e_busy = 1;
      end
      P_POST:  e_busy = 1;
      P_PULSE: begin e_d0 = (m_owner == 0); e_d1 = (m_owner == 1); end
      default: ;
    endcase
    check_eq("busy", bus.busy, e_busy);
    check_eq("mem_we", bus.mem_we, e_we);
    check_eq("mem_re", bus.mem_re, e_re);
    check_eq("mem_addr", bus.mem_addr, e_addr);
    check_eq("mem_wdata", bus.mem_wdata, e_wd);
    check_eq("miss_done0", bus.miss_done0, e_d0);
    check_eq("miss_done1", bus.miss_done1, e_d1);
    check_eq("fill_line", bus.fill_line, fill_exp);
    if (ph == P_PULSE) check_eq("latency", cyc - grant_cyc, lat_exp);

    for (int i = 0; i < 2; i++) begin
      if (drop_pend[i]) begin want[i] = 0; dropped[i] = 0; drop_pend[i] = 0; end
      done_obs = (i == 0) ? bus.miss_done0 : bus.miss_done1;
      if (done_obs && want[i]) drop_pend[i] = 1;
      if (rand_cores) begin
        if (!want[i] && $urandom_range(0, 3) == 0) begin
          randomize_core(i);
          want[i] = 1;
        end else if (want[i] && !drop_pend[i] && m_owner == i &&
                     (ph == P_CMD || ph == P_POST)) begin
          randomize_core(i);
          if ($urandom_range(0, 7) == 0) dropped[i] = 1;
        end
      end
    end
    if (t5_mode && ph == P_CMD && m_owner == 0) begin
      if (q[0].we && !want[1]) raise(1, 13'h1F3B, 1'b0, 5'h02, 64'h1111_2222_3333_4444);
      if (!q[0].we) dropped[0] = 1;
    end
    drive_cores();

    if (rst_cycles > 0) begin rst_n = 0; rst_cycles--; end
    else rst_n = 1;

    rd = {$urandom, $urandom};
    if (ph == P_CMD) begin
      if (age == 0) wait_n = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
      rdy = (age == wait_n);
    end else begin
      rdy = 1'($urandom_range(0, 1));
    end
    bus.mem_rdata = rd;
    bus.mem_rdy   = rdy;

    cur = ph;
    if (!rst_n) begin
      ph = P_IDLE; q.delete(); m_rr = 0; fill_exp = '0; age = 0;
      dropped[0] = 0; dropped[1] = 0;
    end else begin
      case (cur)
        P_CMD: begin
          if (rdy) begin
            lat_exp += age;
            if (!q[0].we) fill_exp = rd;
            void'(q.pop_front());
            age = 0;
            ph = (q.size() != 0) ? P_CMD : P_POST;
          end else begin
            age++;
          end
        end
        P_POST:  ph = P_PULSE;
        P_PULSE: ph = P_IDLE;
        default: ;
      endcase
      if (cur == P_IDLE || cur == P_PULSE) arbitrate(cur == P_PULSE);
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((want[0] || want[1] || ph != P_IDLE) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain", {62'h0, want[0] || want[1], ph != P_IDLE}, 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      want[i] = 0; dropped[i] = 0; drop_pend[i] = 0;
      c_addr[i] = '0; c_dirty[i] = 0; c_tag[i] = '0; c_line[i] = '0;
    end
    bus.mem_rdata = '0;
    bus.mem_rdy   = 1'b0;
    drive_cores();

    // reset with core0 already requesting, then a clean miss at 0x0A7C
    raise(0, 13'h0A7C, 1'b0, 5'h0, 64'hDEAD_BEEF_0123_4567);
    rst_cycles = 2;
    fixed_wait = 0;
    run_until_idle(50);

    // dirty miss on core1, memory answers after two wait cycles
    raise(1, 13'h0124, 1'b1, 5'h1F, 64'hCAFE_F00D_A5A5_5A5A);
    fixed_wait = 2;
    run_until_idle(50);

    // contention twice: core0, core1, then core0 again
    fixed_wait = 0;
    raise(0, 13'h0400, 1'b0, 5'h03, 64'h0);
    raise(1, 13'h0800, 1'b0, 5'h04, 64'h0);
    run_until_idle(50);
    raise(0, 13'h0C04, 1'b0, 5'h05, 64'h0);
    raise(1, 13'h1008, 1'b0, 5'h06, 64'h0);
    run_until_idle(50);

    // owner drops during fill; core1 arrives during write-back
    fixed_wait = 1;
    t5_mode = 1;
    raise(0, 13'h0ABC, 1'b1, 5'h0B, 64'h0BAD_0BAD_0BAD_0BAD);
    run_until_idle(80);
    t5_mode = 0;

    // reset in the middle of a write-back wait
    fixed_wait = 3;
    raise(0, 13'h1555, 1'b1, 5'h15, 64'h5555_AAAA_5555_AAAA);
    for (int n = 0; n < 20 && !(ph == P_CMD && q.size() != 0 && q[0].we && age > 0); n++)
      step();
    rst_cycles = 1;
    for (int n = 0; n < 3; n++) step();
    run_until_idle(80);

    // randomized traffic with occasional resets
    fixed_wait = -1;
    rand_cores = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) rst_cycles = 1;
      step();
    end
    rand_cores = 0;
    run_until_idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
